// File: rtl/imem_load_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : imem_load_arbiter_if
// Purpose  : Bundle of fetch, loader, memory and core-control signals around
//            the instruction-memory arbiter.
// Revision : 1.0
// ============================================================================
interface imem_load_arbiter_if #(
  parameter int ADDR_W = 14
);
  logic              load_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_en;
  logic              fetch_valid;
  logic              ld_valid;
  logic [31:0]       ld_data;
  logic              ld_ready;
  logic              ld_done;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [31:0]       mem_wdata;
  logic              cpu_hold;
  logic              cpu_rst;
  logic [ADDR_W:0]   load_count;
  logic              load_err;

  modport master (
    input  load_req, fetch_addr, fetch_en, ld_valid, ld_data, ld_done,
    output fetch_valid, ld_ready, mem_addr, mem_we, mem_wdata,
           cpu_hold, cpu_rst, load_count, load_err
  );

  modport slave (
    output load_req, fetch_addr, fetch_en, ld_valid, ld_data, ld_done,
    input  fetch_valid, ld_ready, mem_addr, mem_we, mem_wdata,
           cpu_hold, cpu_rst, load_count, load_err
  );
endinterface
`default_nettype wire

// File: rtl/imem_load_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : imem_load_arbiter
// Purpose  : Shares the single-port instruction memory between fetch and the
//            UART program loader; freezes and restarts the core around a load.
// Revision : 1.0
// ============================================================================
module imem_load_arbiter #(
  parameter int ADDR_W  = 14,
  parameter int RST_CYC = 4
) (
  input  logic                clk,
  input  logic                rst,
  imem_load_arbiter_if.master bus
);

  localparam int CNT_W = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    DRAIN   = 2'd1,
    LOAD    = 2'd2,
    RESTART = 2'd3
  } state_t;

  state_t            r_state;
  logic [ADDR_W:0]   r_ptr;
  logic [CNT_W-1:0]  r_rcnt;
  logic              r_err;
  logic              r_fetch_valid;
  logic              r_hold;
  logic              r_cpu_rst;

  logic              w_ready;
  logic              w_xfer;
  logic              w_exit;

  // The pointer's MSB marks a full memory; it never advances past 2^ADDR_W.
  always_comb begin
    w_ready = (r_state == LOAD) && !r_ptr[ADDR_W];
    w_xfer  = w_ready && bus.ld_valid;
    w_exit  = bus.ld_done || !bus.load_req;
  end

  always_comb begin
    bus.mem_addr  = '0;
    bus.mem_we    = w_xfer;
    bus.mem_wdata = w_xfer ? bus.ld_data : 32'd0;
    case (r_state)
      RUN:     bus.mem_addr = bus.fetch_addr;
      LOAD:    bus.mem_addr = r_ptr[ADDR_W-1:0];
      default: bus.mem_addr = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= RUN;
      r_ptr         <= '0;
      r_rcnt        <= '0;
      r_err         <= 1'b0;
      r_fetch_valid <= 1'b0;
      r_hold        <= 1'b0;
      r_cpu_rst     <= 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          r_fetch_valid <= bus.fetch_en;
          if (bus.load_req) begin
            r_state <= DRAIN;
            r_hold  <= 1'b1;
          end
        end
        DRAIN: begin
          r_fetch_valid <= 1'b0;
          r_ptr         <= '0;
          r_err         <= 1'b0;
          r_state       <= LOAD;
        end
        LOAD: begin
          if (w_xfer) begin
            r_ptr <= r_ptr + 1'b1;
          end
          if (bus.ld_valid && r_ptr[ADDR_W]) begin
            r_err <= 1'b1;
          end
          if (w_exit) begin
            r_state   <= RESTART;
            r_cpu_rst <= 1'b1;
            r_rcnt    <= '0;
          end
        end
        RESTART: begin
          if (r_rcnt == CNT_W'(RST_CYC - 1)) begin
            r_state   <= RUN;
            r_hold    <= 1'b0;
            r_cpu_rst <= 1'b0;
          end else begin
            r_rcnt <= r_rcnt + 1'b1;
          end
        end
        default: r_state <= RUN;
      endcase
    end
  end

  always_comb begin
    bus.ld_ready    = w_ready;
    bus.fetch_valid = r_fetch_valid;
    bus.cpu_hold    = r_hold;
    bus.cpu_rst     = r_cpu_rst;
    bus.load_count  = r_ptr;
    bus.load_err    = r_err;
  end

endmodule
`default_nettype wire

// File: tb/tb_imem_load_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_load_arbiter
// Purpose  : Randomized self-checking bench for imem_load_arbiter, exercising
//            a 14-bit and a 2-bit address instance against a word-count model.
// Revision : 1.0
// ============================================================================
module tb_imem_load_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  int          sel;
  logic        req, fe, lv, ldone;
  logic [13:0] fa;
  logic [31:0] ld;

  int cmp  = 0;
  int mism = 0;
  int depth;
  logic [31:0] words[$];

  always #5 clk = ~clk;

  imem_load_arbiter_if #(.ADDR_W(14)) ifa ();
  imem_load_arbiter_if #(.ADDR_W(2))  ifb ();

  imem_load_arbiter #(.ADDR_W(14), .RST_CYC(4)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  imem_load_arbiter #(.ADDR_W(2),  .RST_CYC(4)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

  assign ifa.load_req   = req && (sel == 0);
  assign ifb.load_req   = req && (sel == 1);
  assign ifa.fetch_addr = fa;
  assign ifb.fetch_addr = fa[1:0];
  assign ifa.fetch_en   = fe;
  assign ifb.fetch_en   = fe;
  assign ifa.ld_valid   = lv && (sel == 0);
  assign ifb.ld_valid   = lv && (sel == 1);
  assign ifa.ld_data    = ld;
  assign ifb.ld_data    = ld;
  assign ifa.ld_done    = ldone && (sel == 0);
  assign ifb.ld_done    = ldone && (sel == 1);

  logic        o_we, o_rdy, o_fv, o_hold, o_crst, o_err;
  logic [13:0] o_addr;
  logic [31:0] o_wdata;
  logic [14:0] o_count;

  always_comb begin
    if (sel == 1) begin
      o_we = ifb.mem_we; o_rdy = ifb.ld_ready; o_fv = ifb.fetch_valid;
      o_hold = ifb.cpu_hold; o_crst = ifb.cpu_rst; o_err = ifb.load_err;
      o_addr = {12'd0, ifb.mem_addr}; o_wdata = ifb.mem_wdata;
      o_count = {12'd0, ifb.load_count};
    end else begin
      o_we = ifa.mem_we; o_rdy = ifa.ld_ready; o_fv = ifa.fetch_valid;
      o_hold = ifa.cpu_hold; o_crst = ifa.cpu_rst; o_err = ifa.load_err;
      o_addr = ifa.mem_addr; o_wdata = ifa.mem_wdata;
      o_count = ifa.load_count;
    end
  end

  task automatic adv();
    @(posedge clk); #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic fill(input int n, input bit fixed);
    words.delete();
    for (int i = 0; i < n; i++) words.push_back($urandom);
    if (fixed) begin
      words[0] = 32'h00500093; words[1] = 32'h00100113; words[2] = 32'h002081B3;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 0; fe = 0; lv = 0; ldone = 0; fa = '0; ld = '0; sel = 0;
    adv(); adv();
    rst = 1'b0;
    for (int s = 0; s < 2; s++) begin
      sel = s;
      settle();
      cmp++;
      if ({o_fv, o_hold, o_crst, o_rdy, o_we, o_err} !== 6'b0 || o_count !== 15'd0) begin
        mism++;
        $display("FAIL reset_state dut=%0d got fv/hold/rst/rdy/we/err=%b count=%0d exp all 0",
                 s, {o_fv, o_hold, o_crst, o_rdy, o_we, o_err}, o_count);
      end
      adv();
    end
  endtask

  task automatic test_fetch();
    logic prev_en = 1'b0;
    sel = 0;
    for (int i = 0; i < 20; i++) begin
      if (i < 3) begin fa = 14'(i); fe = 1'b1; end
      else begin fa = 14'($urandom); fe = 1'($urandom_range(0, 1)); end
      settle();
      cmp++;
      if (o_addr !== fa || o_we !== 1'b0) begin
        mism++; $display("FAIL fetch_addr got addr=%0h we=%0b exp addr=%0h we=0", o_addr, o_we, fa);
      end
      cmp++;
      if (o_fv !== prev_en || o_hold !== 1'b0 || o_rdy !== 1'b0) begin
        mism++;
        $display("FAIL fetch_valid got fv=%0b hold=%0b rdy=%0b exp fv=%0b hold=0 rdy=0",
                 o_fv, o_hold, o_rdy, prev_en);
      end
      prev_en = fe;
      adv();
    end
  endtask

  // mode 0: ld_done after the last word, 1: ld_done with the last word, 2: load_req drop
  task automatic run_load(input int s, input int n, input int mode, input bit keep);
    int  cnt  = 0;
    int  sent = 0;
    bit  err  = 0;
    bit  done = 0;
    bit  exp_we;
    sel = s;
    depth = (s == 1) ? 4 : 16384;
    req = 1; fe = 1; fa = 14'($urandom); lv = 0; ldone = 0;
    settle();
    cmp++;
    if (o_hold !== 1'b0) begin mism++; $display("FAIL run_hold got=%0b exp=0", o_hold); end
    adv();
    fe = 0;
    settle();
    cmp++;
    if ({o_hold, o_fv, o_we, o_rdy, o_crst} !== 5'b11000) begin
      mism++; $display("FAIL drain got hold/fv/we/rdy/rst=%b exp=11000", {o_hold, o_fv, o_we, o_rdy, o_crst});
    end
    adv();
    for (int c = 0; c < 200 && !done; c++) begin
      fe = 1'($urandom_range(0, 1)); fa = 14'($urandom); lv = 0; ldone = 0;
      if (sent == n && mode != 1) begin
        if (mode == 2) req = 0; else ldone = 1;
        done = 1;
      end else if (sent < n) begin
        lv = ($urandom_range(0, 2) != 0);
        if (lv) ld = words[sent];
        if (mode == 1 && lv && sent == n - 1) begin ldone = 1; done = 1; end
      end
      settle();
      exp_we = lv && (cnt < depth);
      cmp++;
      if ({o_hold, o_crst, o_fv} !== 3'b100 || o_rdy !== (cnt < depth) || o_we !== exp_we) begin
        mism++;
        $display("FAIL load_ctrl got hold/rst/fv=%b rdy=%0b we=%0b exp 100 rdy=%0b we=%0b",
                 {o_hold, o_crst, o_fv}, o_rdy, o_we, (cnt < depth), exp_we);
      end
      if (exp_we) begin
        cmp++;
        if (o_addr !== 14'(cnt) || o_wdata !== ld) begin
          mism++; $display("FAIL load_write got addr=%0d data=%h exp addr=%0d data=%h", o_addr, o_wdata, cnt, ld);
        end
      end
      cmp++;
      if (o_count !== 15'(cnt) || o_err !== err) begin
        mism++; $display("FAIL load_count got count=%0d err=%0b exp count=%0d err=%0b", o_count, o_err, cnt, err);
      end
      if (lv) begin
        if (cnt < depth) cnt++; else err = 1;
        sent++;
      end
      adv();
    end
    cmp++;
    if (!done) begin mism++; $display("FAIL load_timeout got sent=%0d exp %0d", sent, n); end
    lv = 0; ldone = 0;
    if (!keep) req = 0;
    for (int r = 0; r < 4; r++) begin
      settle();
      cmp++;
      if ({o_crst, o_hold, o_we, o_rdy} !== 4'b1100 || o_count !== 15'(cnt) || o_err !== err) begin
        mism++;
        $display("FAIL restart cyc=%0d got rst/hold/we/rdy=%b count=%0d err=%0b exp 1100 count=%0d err=%0b",
                 r, {o_crst, o_hold, o_we, o_rdy}, o_count, o_err, cnt, err);
      end
      adv();
    end
    settle();
    cmp++;
    if ({o_hold, o_crst, o_fv, o_rdy} !== 4'b0 || o_count !== 15'(cnt) || o_err !== err) begin
      mism++;
      $display("FAIL run_after got hold/rst/fv/rdy=%b count=%0d err=%0b exp 0000 count=%0d err=%0b",
               {o_hold, o_crst, o_fv, o_rdy}, o_count, o_err, cnt, err);
    end
    adv();
    settle();
    cmp++;
    if (o_hold !== keep) begin mism++; $display("FAIL reentry_hold got=%0b exp=%0b", o_hold, keep); end
    if (keep) begin
      adv();
      req = 0;
      settle();
      cmp++;
      if (o_count !== 15'd0 || o_err !== 1'b0 || o_rdy !== 1'b1) begin
        mism++; $display("FAIL reentry_ptr got count=%0d err=%0b rdy=%0b exp 0 0 1", o_count, o_err, o_rdy);
      end
      for (int r = 0; r < 5; r++) adv();
      settle();
      cmp++;
      if (o_hold !== 1'b0 || o_crst !== 1'b0) begin
        mism++; $display("FAIL reentry_end got hold=%0b rst=%0b exp 0 0", o_hold, o_crst);
      end
    end
    adv();
  endtask

  task automatic test_reset_mid_load(input int s, input int n);
    int exp_cnt;
    sel = s;
    depth = (s == 1) ? 4 : 16384;
    exp_cnt = (n < depth) ? n : depth;
    req = 1; fe = 0; lv = 0; ldone = 0;
    adv(); adv();
    for (int i = 0; i < n; i++) begin
      lv = 1; ld = $urandom;
      adv();
    end
    lv = 0;
    settle();
    cmp++;
    if (o_count !== 15'(exp_cnt) || o_err !== (n > depth)) begin
      mism++; $display("FAIL midload got count=%0d err=%0b exp count=%0d err=%0b", o_count, o_err, exp_cnt, (n > depth));
    end
    adv();
    rst = 1; req = 0;
    adv();
    rst = 0;
    for (int r = 0; r < 6; r++) begin
      settle();
      cmp++;
      if ({o_hold, o_crst, o_rdy, o_err} !== 4'b0 || o_count !== 15'd0) begin
        mism++;
        $display("FAIL reset_midload cyc=%0d got hold/rst/rdy/err=%b count=%0d exp 0000 count=0",
                 r, {o_hold, o_crst, o_rdy, o_err}, o_count);
      end
      adv();
    end
  endtask

  task automatic test_random_loads();
    for (int k = 0; k < 8; k++) begin
      int s = $urandom_range(0, 1);
      int n = $urandom_range(1, 7);
      fill(n, 0);
      run_load(s, n, $urandom_range(0, 2), 0);
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    fill(3, 1); run_load(0, 3, 0, 0);
    fill(2, 0); run_load(0, 2, 1, 0);
    fill(5, 0); run_load(1, 5, 0, 0);
    test_reset_mid_load(0, 2);
    test_reset_mid_load(1, 5);
    fill(3, 1); run_load(0, 3, 0, 1);
    test_random_loads();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mism);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/imem_load_arbiter.md
Name: imem_load_arbiter

Overview:
- Shares the single-port instruction memory between the fetch stage and the UART program loader.
- In normal running, fetch owns the memory read-only.
- On a load request, it freezes the core, hands the memory to the loader's word stream, then pulses a core reset so execution restarts from PC 0.
- Sits between the fetch stage, the UART word assembler and the instruction memory macro, which has a 1-cycle synchronous read.

Parameters:
- ADDR_W, 14, word-address width of instruction memory (depth = 2^ADDR_W words).
- RST_CYC, 4, number of cycles cpu_rst is held high after a load; must be >= 1.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- load_req  in  1  level from the board switch; 1 = enter program-load mode.
- fetch_addr  in  ADDR_W  word address from fetch (pc[ADDR_W+1:2]).
- fetch_en  in  1  fetch requests a read this cycle.
- fetch_valid  out  1  memory douta holds the fetch word requested in the previous cycle.
- ld_valid  in  1  loader word valid.
- ld_data  in  32  loader word.
- ld_ready  out  1  arbiter accepts a loader word this cycle.
- ld_done  in  1  1-cycle pulse: upload finished.
- mem_addr  out  ADDR_W  memory word address.
- mem_we  out  1  memory write enable.
- mem_wdata  out  32  memory write data.
- cpu_hold  out  1  freezes PC and pipeline.
- cpu_rst  out  1  core reset; active-high.
- load_count  out  ADDR_W+1  number of words written in the most recent load.
- load_err  out  1  sticky overflow flag.

Behaviour:
- States: RUN, DRAIN, LOAD, RESTART.
- Reset:
  - state=RUN, ptr=0, load_count=0, load_err=0, fetch_valid=0, cpu_hold=0, cpu_rst=0, ld_ready=0.
  - rst has priority in every state. Reset mid-LOAD abandons the load: memory keeps the partial contents, and there is no cpu_rst pulse.
- RUN:
  - mem_addr=fetch_addr, mem_we=0, mem_wdata=0, ld_ready=0.
  - fetch_valid (registered) = fetch_en of the previous cycle.
  - load_req=1 -> DRAIN.
- DRAIN (exactly 1 cycle):
  - cpu_hold=1, mem_we=0.
  - fetch_valid still reflects the read issued in the last RUN cycle, then drops to 0.
  - ptr<=0, load_err<=0.
  - Always -> LOAD.
- LOAD:
  - cpu_hold=1, fetch_valid=0.
  - ld_ready=1 when ptr < 2^ADDR_W.
  - Transfer = ld_valid & ld_ready. In that same cycle, combinationally: mem_we=1, mem_addr=ptr[ADDR_W-1:0], mem_wdata=ld_data. Then ptr<=ptr+1.
  - ptr is ADDR_W+1 bits wide and never wraps.
  - ld_valid while ptr==2^ADDR_W: the word is dropped and load_err<=1.
  - load_count tracks ptr continuously.
  - Exit on ld_done=1 or load_req=0 -> RESTART. A transfer in the exit cycle is still written.
- RESTART:
  - cpu_hold=1, cpu_rst=1 for exactly RST_CYC cycles, mem_we=0, ld_ready=0.
  - Then -> RUN, with cpu_hold=0 and cpu_rst=0 in the first RUN cycle.
  - load_req still 1 on RESTART exit: stays in RUN for 1 cycle, then DRAIN again (level-triggered re-entry).
- load_count and load_err hold their values in RUN until the next DRAIN.
- cpu_hold and cpu_rst are registered (state-decoded). mem_* are combinational from state, ptr and the inputs.

Test Plan:
- Reset, then fetch_en=1 with fetch_addr=0,1,2 -> mem_addr follows the same cycle, mem_we=0, fetch_valid=1 from the 2nd cycle on, cpu_hold=0.
- load_req=1 during RUN, then stream 3 words 0x00500093, 0x00100113, 0x002081B3 with ld_valid gaps, then ld_done -> the sequence below:
  - DRAIN for 1 cycle.
  - Writes at addresses 0, 1, 2 with matching data, mem_we high only on the transfer cycles.
  - load_count=3.
  - cpu_rst high for 4 cycles, then RUN.
- ld_done coincident with the 2nd word's transfer -> the word is written at address 1, load_count=2, then RESTART.
- ADDR_W=2: stream 5 words -> 4 writes at addresses 0..3. ld_ready=0 after the 4th, and the 5th word sets load_err=1. load_count=4 and stays 4 in RUN.
- rst pulse in the middle of LOAD after 2 words -> next cycle state=RUN, cpu_hold=0, cpu_rst never asserted, load_count=0, load_err=0.
- load_req held at 1 through the whole load -> after RESTART, exactly 1 RUN cycle, then DRAIN, with ptr restarting at 0.
